// File: rtl/aes_pkg.sv
// aes_pkg: FSM states, round constants, key-size helpers and AES state transforms for aes_enc_core
package aes_pkg;
    typedef enum logic [2:0] {NOKEY, KEXP, READY, ROUND, DONE} state_t;
    localparam logic [7:0] RCON [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                           8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    function automatic int nk_of(input int key_bits);
        return key_bits / 32;
    endfunction
    function automatic int nr_of(input int key_bits);
        return key_bits / 32 + 6;
    endfunction
    function automatic int nw_of(input int key_bits);
        return 4 * (key_bits / 32 + 7);
    endfunction
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xtime(x);
        end
        return p;
    endfunction
    // state byte b = 4*column + row lives at [127-8b -: 8]
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
        return o;
    endfunction
    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127 - 32 * c -: 32];
            o[127 - 32 * c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                     xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box (GF(2^8) inverse as a^254, then the affine map)
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] x2, x3, x12, t, inv;
    always_comb begin
        x2 = gf_mul(a, a);
        x3 = gf_mul(x2, a);
        x12 = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        t = gf_mul(x12, x3);
        for (int i = 0; i < 4; i++) t = gf_mul(t, t);
        inv = gf_mul(gf_mul(t, x12), x2);
        y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

// File: rtl/aes_enc_core.sv
// aes_enc_core: iterative AES-128/192/256 encryptor, one key word or round per cycle; AES_ZEROIZE_EN adds a zeroize input
module aes_enc_core
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef AES_ZEROIZE_EN
    input  logic                zeroize,
`endif
    input  logic                key_load,
    input  logic [KEY_BITS-1:0] key,
    output logic                key_ready,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data
);
    localparam int NK = nk_of(KEY_BITS);
    localparam int NR = nr_of(KEY_BITS);
    localparam int NW = nw_of(KEY_BITS);
    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_enc_core: KEY_BITS must be 128, 192 or 256");
    end
    state_t state;
    logic [NW-1:0][31:0] w;
    logic [127:0] st, sb, sr, rk, rnd_out;
    logic [3:0] rnd, ri;
    logic [5:0] widx, base;
    logic [2:0] kpos;
    logic [31:0] prev, sub_in, sub_out, temp, new_w;
    logic zero;
`ifdef AES_ZEROIZE_EN
    assign zero = zeroize;
`else
    assign zero = 1'b0;
`endif
    for (genvar i = 0; i < 16; i++) begin : g_sb
        aes_sbox u_sbox (.a(st[127-8*i -: 8]), .y(sb[127-8*i -: 8]));
    end
    for (genvar i = 0; i < 4; i++) begin : g_sw
        aes_sbox u_sbox (.a(sub_in[31-8*i -: 8]), .y(sub_out[31-8*i -: 8]));
    end
    // rnd rests at 0 outside ROUND, so rk doubles as the whitening key in READY
    always_comb begin
        base = {rnd, 2'b00};
        rk = {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
        sr = shift_rows(sb);
        rnd_out = (rnd == 4'(NR) ? sr : mix_columns(sr)) ^ rk;
        prev = w[widx - 6'd1];
        sub_in = kpos == 3'd0 ? {prev[23:0], prev[31:24]} : prev;
        temp = kpos == 3'd0 ? sub_out ^ {RCON[ri], 24'h0} : (NK == 8 && kpos == 3'd4) ? sub_out : prev;
        new_w = w[widx - 6'(NK)] ^ temp;
        in_ready = state == READY && !key_load && !zero;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= NOKEY;
            w <= '0;
            st <= '0;
            rnd <= '0;
            ri <= '0;
            widx <= '0;
            kpos <= '0;
            key_ready <= 1'b0;
            out_valid <= 1'b0;
            out_data <= '0;
        end else if (zero) begin
            state <= NOKEY;
            w <= '0;
            st <= '0;
            rnd <= '0;
            key_ready <= 1'b0;
            out_valid <= 1'b0;
            out_data <= '0;
        end else if (key_load) begin
            for (int k = 0; k < NK; k++) w[k] <= key[KEY_BITS-1-32*k -: 32];
            state <= KEXP;
            widx <= 6'(NK);
            kpos <= '0;
            ri <= 4'd1;
            rnd <= '0;
            key_ready <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                KEXP: begin
                    w[widx] <= new_w;
                    widx <= widx + 6'd1;
                    kpos <= kpos == 3'(NK - 1) ? 3'd0 : kpos + 3'd1;
                    ri <= kpos == 3'd0 ? ri + 4'd1 : ri;
                    if (widx == 6'(NW - 1)) begin
                        state <= READY;
                        key_ready <= 1'b1;
                    end
                end
                READY: if (in_valid) begin
                    st <= in_data ^ rk;
                    rnd <= 4'd1;
                    state <= ROUND;
                end
                ROUND: if (rnd == 4'(NR)) begin
                    out_data <= rnd_out;
                    out_valid <= 1'b1;
                    rnd <= '0;
                    state <= DONE;
                end else begin
                    st <= rnd_out;
                    rnd <= rnd + 4'd1;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state <= READY;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_enc_core.sv
// tb_aes_enc_core: directed and randomized checks of aes_enc_core (128/192/256) against a byte-level AES model
module tb_aes_enc_core;
    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] PT128 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT128 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PTV = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic kl[3], iv[3], ordy[3], kr[3], ir[3], ov[3];
    logic [255:0] key_r[3];
    logic [127:0] id[3], od[3];
`ifdef AES_ZEROIZE_EN
    logic zz[3];
`endif
    int tests = 0;
    int fails = 0;
    logic [7:0] sbt[256];
    always #5 clk = ~clk;
    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_enc_core #(.KEY_BITS(128 + 64 * g)) dut (
            .clk(clk),
            .rst_n(rst_n),
`ifdef AES_ZEROIZE_EN
            .zeroize(zz[g]),
`endif
            .key_load(kl[g]),
            .key(key_r[g][255 -: 128 + 64 * g]),
            .key_ready(kr[g]),
            .in_valid(iv[g]),
            .in_ready(ir[g]),
            .in_data(id[g]),
            .out_valid(ov[g]),
            .out_ready(ordy[g]),
            .out_data(od[g])
        );
    end
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic chkb(input string tag, input logic got, input logic exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p ^= {8'h00, a} << i;
        for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h011b << (i - 8);
        return p[7:0];
    endfunction
    function automatic logic [7:0] sbox_of(input logic [7:0] x);
        logic [7:0] b, s, c;
        b = 8'h00;
        c = 8'h63;
        for (int y = 1; y < 256; y++) if (gm(x, 8'(y)) == 8'h01) b = 8'(y);
        for (int i = 0; i < 8; i++)
            s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ c[i];
        return s;
    endfunction
    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbt[x[31:24]], sbt[x[23:16]], sbt[x[15:8]], sbt[x[7:0]]};
    endfunction
    function automatic logic [127:0] ref_enc(input logic [255:0] k, input int nk, input logic [127:0] pt);
        logic [31:0] w[60];
        logic [7:0] s[16], t[16], a[4], rc;
        logic [31:0] x;
        logic [127:0] o;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = k[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            x = w[i - 1];
            if (i % nk == 0) begin
                x = subw({x[23:0], x[31:24]}) ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) x = subw(x);
            w[i] = w[i - nk] ^ x;
        end
        for (int b = 0; b < 16; b++) s[b] = pt[127 - 8 * b -: 8] ^ w[b / 4][31 - 8 * (b % 4) -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int b = 0; b < 16; b++) t[b] = sbt[s[b]];
            for (int b = 0; b < 16; b++) s[b] = t[4 * ((b / 4 + b % 4) % 4) + b % 4];
            if (r < nr)
                for (int c = 0; c < 4; c++) begin
                    for (int j = 0; j < 4; j++) a[j] = s[4 * c + j];
                    for (int j = 0; j < 4; j++)
                        s[4 * c + j] = gm(a[j], 8'h02) ^ gm(a[(j + 1) % 4], 8'h03) ^ a[(j + 2) % 4] ^ a[(j + 3) % 4];
                end
            for (int b = 0; b < 16; b++) s[b] ^= w[4 * r + b / 4][31 - 8 * (b % 4) -: 8];
        end
        for (int b = 0; b < 16; b++) o[127 - 8 * b -: 8] = s[b];
        return o;
    endfunction
    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction
    function automatic logic [255:0] rand256();
        return {rand128(), rand128()};
    endfunction
    task automatic wait_key(input int g, input string tag);
        int cnt;
        logic seen;
        cnt = 0;
        seen = 1'b0;
        while (!kr[g] && cnt < 200) begin
            @(negedge clk);
            cnt++;
            seen = seen | ov[g];
        end
        chk({tag, "/kexp_cycles"}, 128'(cnt), 128'(4 * (4 + 2 * g + 7) - (4 + 2 * g)));
        chkb({tag, "/no_out_valid_in_kexp"}, seen, 1'b0);
    endtask
    task automatic load_key(input int g, input logic [255:0] k, input string tag);
        key_r[g] = k;
        kl[g] = 1'b1;
        @(negedge clk);
        kl[g] = 1'b0;
        chkb({tag, "/key_ready_low"}, kr[g], 1'b0);
        chkb({tag, "/in_ready_low"}, ir[g], 1'b0);
        wait_key(g, tag);
    endtask
    task automatic release_out(input int g, input string tag);
        ordy[g] = 1'b1;
        @(negedge clk);
        ordy[g] = 1'b0;
        chkb({tag, "/out_valid_drop"}, ov[g], 1'b0);
        chkb({tag, "/in_ready_back"}, ir[g], 1'b1);
    endtask
    task automatic send(input int g, input logic [127:0] pt, input logic [127:0] exp, input string tag, input bit rel);
        int cnt;
        logic seen;
        cnt = 0;
        seen = 1'b0;
        chkb({tag, "/in_ready_before"}, ir[g], 1'b1);
        iv[g] = 1'b1;
        id[g] = pt;
        @(negedge clk);
        iv[g] = 1'b0;
        while (!ov[g] && cnt < 100) begin
            seen = seen | ir[g];
            @(negedge clk);
            cnt++;
        end
        chk({tag, "/latency"}, 128'(cnt), 128'(4 + 2 * g + 6));
        chk({tag, "/ct"}, od[g], exp);
        chkb({tag, "/in_ready_low_busy"}, seen | ir[g], 1'b0);
        if (rel) release_out(g, tag);
    endtask
    initial begin
        logic [255:0] k;
        logic [127:0] pt, ct;
        logic seen;
        for (int g = 0; g < 3; g++) begin
            kl[g] = 1'b0;
            iv[g] = 1'b0;
            ordy[g] = 1'b0;
            key_r[g] = '0;
            id[g] = '0;
`ifdef AES_ZEROIZE_EN
            zz[g] = 1'b0;
`endif
        end
        for (int x = 0; x < 256; x++) sbt[x] = sbox_of(8'(x));
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chkb($sformatf("reset/g%0d/key_ready", g), kr[g], 1'b0);
            chkb($sformatf("reset/g%0d/in_ready", g), ir[g], 1'b0);
            chkb($sformatf("reset/g%0d/out_valid", g), ov[g], 1'b0);
            chk($sformatf("reset/g%0d/out_data", g), od[g], 128'h0);
        end
        rst_n = 1'b1;
        load_key(0, K128, "aes128_vec");
        send(0, PT128, CT128, "aes128_vec", 1'b1);
        pt = rand128();
        ct = ref_enc(K128, 4, pt);
        send(0, pt, ct, "backpressure_blk1", 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("backpressure/out_data_stable", od[0], ct);
            chkb("backpressure/out_valid_held", ov[0], 1'b1);
            chkb("backpressure/in_ready_low", ir[0], 1'b0);
        end
        release_out(0, "backpressure_release");
        pt = rand128();
        send(0, pt, ref_enc(K128, 4, pt), "backpressure_blk2", 1'b1);
        load_key(1, K192, "aes192_vec");
        send(1, PTV, CT192, "aes192_vec", 1'b1);
        load_key(2, K256, "aes256_vec");
        send(2, PTV, CT256, "aes256_vec", 1'b1);
        for (int g = 0; g < 3; g++)
            for (int r = 0; r < 2; r++) begin
                k = rand256();
                load_key(g, k, $sformatf("rand_g%0d_key", g));
                for (int p = 0; p < 3; p++) begin
                    pt = rand128();
                    send(g, pt, ref_enc(k, 4 + 2 * g, pt), $sformatf("rand_g%0d_blk", g), 1'b1);
                end
            end
        load_key(0, rand256(), "midround_key1");
        iv[0] = 1'b1;
        id[0] = rand128();
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (4) @(negedge clk);
        key_r[0] = K128;
        kl[0] = 1'b1;
        @(negedge clk);
        kl[0] = 1'b0;
        chkb("midround/out_valid", ov[0], 1'b0);
        chkb("midround/key_ready", kr[0], 1'b0);
        chkb("midround/in_ready", ir[0], 1'b0);
        wait_key(0, "midround_rekey");
        send(0, PT128, CT128, "midround_newkey", 1'b1);
        key_r[0] = K128;
        kl[0] = 1'b1;
        iv[0] = 1'b1;
        id[0] = rand128();
        #1 chkb("coincident/in_ready_forced_low", ir[0], 1'b0);
        @(negedge clk);
        kl[0] = 1'b0;
        iv[0] = 1'b0;
        chkb("coincident/key_ready", kr[0], 1'b0);
        wait_key(0, "coincident_rekey");
        send(0, PT128, CT128, "coincident_after", 1'b1);
        key_r[0] = rand256();
        kl[0] = 1'b1;
        @(negedge clk);
        kl[0] = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chkb("rst_kexp/key_ready", kr[0], 1'b0);
        chkb("rst_kexp/in_ready", ir[0], 1'b0);
        chkb("rst_kexp/out_valid", ov[0], 1'b0);
        chk("rst_kexp/out_data", od[0], 128'h0);
        chk("rst_kexp/out_data_g1", od[1], 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        iv[0] = 1'b1;
        id[0] = rand128();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen = seen | ir[0] | ov[0] | kr[0];
        end
        iv[0] = 1'b0;
        chkb("nokey/in_valid_ignored", seen, 1'b0);
        load_key(0, K128, "rst_done_key");
        send(0, PT128, CT128, "rst_done_blk", 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chkb("rst_done/out_valid", ov[0], 1'b0);
        chk("rst_done/out_data", od[0], 128'h0);
        chkb("rst_done/key_ready", kr[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        k = rand256();
        load_key(1, k, "post_reset_key");
        pt = rand128();
        send(1, pt, ref_enc(k, 6, pt), "post_reset_blk", 1'b1);
`ifdef AES_ZEROIZE_EN
        load_key(0, K128, "zeroize_key");
        send(0, PT128, CT128, "zeroize_blk", 1'b0);
        zz[0] = 1'b1;
        kl[0] = 1'b1;
        key_r[0] = rand256();
        @(negedge clk);
        zz[0] = 1'b0;
        kl[0] = 1'b0;
        chk("zeroize/out_data", od[0], 128'h0);
        chkb("zeroize/key_ready", kr[0], 1'b0);
        chkb("zeroize/out_valid", ov[0], 1'b0);
        chkb("zeroize/in_ready", ir[0], 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            seen = seen | kr[0];
        end
        chkb("zeroize/key_load_ignored", seen, 1'b0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
